// File: rtl/sbox_sub_pipe.sv
// sbox_sub_pipe: LANES-wide pipelined AES SubBytes with valid/ready flow control.
// Optional INV_SBOX_EN adds a per-beat inv port selecting the inverse S-box.
module sbox_sub_pipe #(
   parameter int LANES       = 16,
   parameter int PIPE_STAGES = 2
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [8*LANES-1:0]   in_data,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [8*LANES-1:0]   out_data,
   output logic                 busy
`ifdef INV_SBOX_EN
   ,input  logic                inv
`endif
);
   localparam logic [0:255][7:0] SBOX = {
      128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};
`ifdef INV_SBOX_EN
   localparam logic [0:255][7:0] ISBOX = {
      128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
      128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
      128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
      128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
      128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
      128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
      128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
      128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d};
`endif
   logic [PIPE_STAGES-1:0] valid, ready, up_valid;
   logic [8*LANES-1:0]     data [PIPE_STAGES];
   logic [8*LANES-1:0]     up_data [PIPE_STAGES];
   logic [8*LANES-1:0]     sub;
   logic                   r;
   always_comb begin
      sub = '0;
      for (int i = 0; i < LANES; i++)
`ifdef INV_SBOX_EN
         sub[8*i +: 8] = inv ? ISBOX[in_data[8*i +: 8]] : SBOX[in_data[8*i +: 8]];
`else
         sub[8*i +: 8] = SBOX[in_data[8*i +: 8]];
`endif
   end
   always_comb begin
      up_valid[0] = in_valid;
      up_data[0]  = sub;
      for (int k = 1; k < PIPE_STAGES; k++) begin
         up_valid[k] = valid[k-1];
         up_data[k]  = data[k-1];
      end
   end
   // ready ripples back from out_ready; a stage is free if empty or its successor moves
   always_comb begin
      r = out_ready;
      for (int k = PIPE_STAGES - 1; k >= 0; k--) begin
         r        = !valid[k] || r;
         ready[k] = r;
      end
   end
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         valid <= '0;
         for (int k = 0; k < PIPE_STAGES; k++) data[k] <= '0;
      end else begin
         for (int k = 0; k < PIPE_STAGES; k++)
            if (ready[k]) begin
               valid[k] <= up_valid[k];
               if (up_valid[k]) data[k] <= up_data[k];
            end
      end
   end
   assign in_ready  = rst_n && ready[0];
   assign out_valid = valid[PIPE_STAGES-1];
   assign out_data  = data[PIPE_STAGES-1];
   assign busy      = |valid;
endmodule
